// File: rtl/queue_occ.sv
// Synchronous FIFO using all 2**ADDR_W entries through an explicit occupancy
// counter, with flush, almost-full/empty thresholds and sticky error flags.
module queue_occ #(
    parameter int WIDTH    = 2,
    parameter int ADDR_W   = 8,
    parameter int AF_LEVEL = (1 << ADDR_W) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic              data_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W+1)'(AE_LEVEL);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_acc;
    logic              pop_acc;

    // Flags come only from the registered count, never from pointer equality.
    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    // A full queue may still take a push when a pop frees a slot in the same
    // cycle; an empty queue never forwards a push straight to the output.
    always_comb begin
        pop_acc  = pop & ~empty;
        push_acc = push & (~full | pop_acc);
    end

    always_ff @(posedge clk) begin
        if (push_acc && !flush) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (flush) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= pop_acc;
            if (pop_acc) begin
                data_out <= mem[rd_ptr];
            end
        end
    end

    // Error flags are sticky until reset or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else if (flush) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (push && !push_acc) begin
                ovf_err <= 1'b1;
            end
            if (pop && !pop_acc) begin
                udf_err <= 1'b1;
            end
        end
    end

endmodule
